// File: rtl/wbu_pkg.sv
// Shared definitions for the debug-bus Wishbone supervisor.
package wbu_pkg;

  typedef enum logic [1:0] {
    WBG_IDLE  = 2'd0,
    WBG_BUSY  = 2'd1,
    WBG_ABORT = 2'd2
  } wbg_state_t;

  localparam int WBU_AW            = 32;
  localparam int WBU_DW            = 32;
  localparam int WBU_LGWATCHDOG    = 19;
  localparam int WBU_LGOUTSTANDING = 4;

endpackage

// File: rtl/wbu_wdtimer.sv
// Watchdog counter: clear has priority over enable; terminal flags all-ones.
module wbu_wdtimer #(
  parameter int LGWATCHDOG = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [LGWATCHDOG-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign terminal = &count;

endmodule

// File: rtl/wbu_busguard.sv
// Wishbone bus supervisor: outstanding-request throttle, watchdog timeout,
// synthetic error and bus-reset pulse on abort.
module wbu_busguard import wbu_pkg::*; #(
  parameter int AW            = WBU_AW,
  parameter int DW            = WBU_DW,
  parameter int LGWATCHDOG    = WBU_LGWATCHDOG,
  parameter int LGOUTSTANDING = WBU_LGOUTSTANDING,
  parameter int WDMODE        = 0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_mcyc,
  input  logic                     i_mstb,
  input  logic                     i_mwe,
  input  logic [AW-1:0]            i_maddr,
  input  logic [DW-1:0]            i_mdata,
  input  logic [DW/8-1:0]          i_msel,
  output logic                     o_mack,
  output logic                     o_merr,
  output logic                     o_mstall,
  output logic [DW-1:0]            o_mdata,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [AW-1:0]            o_wb_addr,
  output logic [DW-1:0]            o_wb_data,
  output logic [DW/8-1:0]          o_wb_sel,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_err,
  input  logic [DW-1:0]            i_wb_data,
  output logic                     o_bus_reset,
  output logic                     o_busy,
  output logic [LGOUTSTANDING:0]   o_outstanding,
  output logic [7:0]               o_timeouts
);

  localparam int CW = LGOUTSTANDING + 1;
  localparam logic [CW-1:0] MAX_OUT = {1'b1, {LGOUTSTANDING{1'b0}}};

  wbg_state_t    state, state_nxt;
  logic [CW-1:0] outstanding;
  logic [7:0]    timeouts;
  logic          to_pulse;
  logic          aborting, active, full, accept, ack_ok, err_ok;
  logic          wd_clear, wd_en, wd_term, timeout;

  // Reset gates the slave-side cycle combinationally so it drops at once.
  assign aborting = (state == WBG_ABORT);
  assign active   = !i_reset && !aborting && i_mcyc;
  assign full     = (outstanding == MAX_OUT);

  assign o_wb_cyc  = active;
  assign o_wb_stb  = !i_reset && !aborting && i_mstb && !full;
  assign o_wb_we   = i_mwe;
  assign o_wb_addr = i_maddr;
  assign o_wb_data = i_mdata;
  assign o_wb_sel  = i_msel;
  assign o_mdata   = i_wb_data;
  assign o_mstall  = aborting || i_wb_stall || full;

  assign accept = o_wb_stb && !i_wb_stall;
  assign ack_ok = active && i_wb_ack && (outstanding != '0);
  assign err_ok = active && i_wb_err;

  assign o_mack        = ack_ok;
  assign o_merr        = err_ok || to_pulse;
  assign o_bus_reset   = to_pulse;
  assign o_busy        = (state != WBG_IDLE);
  assign o_outstanding = outstanding;
  assign o_timeouts    = timeouts;

  assign wd_clear = !o_wb_cyc || i_wb_ack || i_wb_err || ((WDMODE != 0) && accept);
  assign wd_en    = (state == WBG_BUSY) && ((outstanding != '0) || i_mstb);
  assign timeout  = wd_term && wd_en && !wd_clear;

  wbu_wdtimer #(.LGWATCHDOG(LGWATCHDOG)) u_wdt (
    .clk      (i_clk),
    .rst      (i_reset),
    .clear    (wd_clear),
    .enable   (wd_en),
    .terminal (wd_term)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      WBG_IDLE:  if (i_mcyc) state_nxt = WBG_BUSY;
      WBG_BUSY: begin
        if (!i_mcyc)                state_nxt = WBG_IDLE;
        else if (err_ok || timeout) state_nxt = WBG_ABORT;
      end
      WBG_ABORT: if (!i_mcyc) state_nxt = WBG_IDLE;
      default:   state_nxt = WBG_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= WBG_IDLE;
      outstanding <= '0;
      to_pulse    <= 1'b0;
      timeouts    <= 8'd0;
    end else begin
      state    <= state_nxt;
      to_pulse <= timeout;
      if (timeout && (timeouts != 8'hff))
        timeouts <= timeouts + 8'd1;
      // Dropping the cycle abandons any in-flight requests.
      if (!active || err_ok || timeout)
        outstanding <= '0;
      else
        outstanding <= outstanding + {{(CW-1){1'b0}}, accept}
                                   - {{(CW-1){1'b0}}, ack_ok};
    end
  end

endmodule

// File: tb/tb_wbu_busguard.sv
// Bench for wbu_busguard: two instances (WDMODE 0/1) on shared stimulus,
// checked every cycle against a cycle-level behavioural model.
module tb_wbu_busguard;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_mcyc, i_mstb, i_mwe;
  logic [31:0] i_maddr, i_mdata;
  logic [3:0]  i_msel;
  logic        i_wb_ack, i_wb_stall, i_wb_err;
  logic [31:0] i_wb_data;

  logic [1:0]       mack, merr, mstall, wb_cyc, wb_stb, wb_we, bus_reset, busy;
  logic [1:0][31:0] mdata, wb_addr, wb_data;
  logic [1:0][3:0]  wb_sel;
  logic [1:0][2:0]  outstanding;
  logic [1:0][7:0]  timeouts;

  always #5 i_clk = ~i_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wbu_busguard #(.AW(32), .DW(32), .LGWATCHDOG(4), .LGOUTSTANDING(2), .WDMODE(g)) u_dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
      .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
      .o_mack(mack[g]), .o_merr(merr[g]), .o_mstall(mstall[g]), .o_mdata(mdata[g]),
      .o_wb_cyc(wb_cyc[g]), .o_wb_stb(wb_stb[g]), .o_wb_we(wb_we[g]),
      .o_wb_addr(wb_addr[g]), .o_wb_data(wb_data[g]), .o_wb_sel(wb_sel[g]),
      .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
      .i_wb_data(i_wb_data),
      .o_bus_reset(bus_reset[g]), .o_busy(busy[g]),
      .o_outstanding(outstanding[g]), .o_timeouts(timeouts[g])
    );
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: outstanding count, idle-cycle watchdog, pending timeout
  // report, phase flags (in a transaction / aborted) and timeout tally.
  int m_cnt[2], m_tmr[2], m_tos[2];
  bit m_busy[2], m_ab[2], m_pend[2];

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_tmr[k] = 0; m_tos[k] = 0;
      m_busy[k] = 0; m_ab[k] = 0; m_pend[k] = 0;
    end
  endtask

  task automatic step(input bit c, input bit s, input bit a, input bit st,
                      input bit e, input logic [31:0] rd);
    @(negedge i_clk);
    i_mcyc = c; i_mstb = s; i_wb_ack = a; i_wb_stall = st; i_wb_err = e; i_wb_data = rd;
    i_mwe = 1'($urandom_range(1)); i_maddr = $urandom; i_mdata = $urandom;
    i_msel = 4'($urandom_range(15));
    #1;
    for (int k = 0; k < 2; k++) begin
      bit act, full, stb_e, ack_e, err_e, acc, counting, clr, to;
      act   = !m_ab[k] && c;
      full  = (m_cnt[k] == 4);
      stb_e = !m_ab[k] && s && !full;
      ack_e = act && a && (m_cnt[k] > 0);
      err_e = act && e;
      chk($sformatf("cyc%0d", k), wb_cyc[k], act);
      chk($sformatf("stb%0d", k), wb_stb[k], stb_e);
      chk($sformatf("stall%0d", k), mstall[k], m_ab[k] || st || full);
      chk($sformatf("mack%0d", k), mack[k], ack_e);
      chk($sformatf("merr%0d", k), merr[k], err_e || m_pend[k]);
      chk($sformatf("busrst%0d", k), bus_reset[k], m_pend[k]);
      chk($sformatf("busy%0d", k), busy[k], m_busy[k] || m_ab[k]);
      chk($sformatf("outst%0d", k), outstanding[k], m_cnt[k]);
      chk($sformatf("tos%0d", k), timeouts[k], m_tos[k]);
      chk($sformatf("pay%0d", k), {wb_addr[k], wb_data[k]}, {i_maddr, i_mdata});
      chk($sformatf("selwe%0d", k), {wb_sel[k], wb_we[k], mdata[k]}, {i_msel, i_mwe, rd});
      acc      = stb_e && !st;
      counting = m_busy[k] && (m_cnt[k] > 0 || s);
      clr      = !act || a || e || (k == 1 && acc);
      to       = counting && !clr && (m_tmr[k] == 15);
      m_tmr[k] = clr ? 0 : counting ? (m_tmr[k] + 1) % 16 : m_tmr[k];
      m_pend[k] = to;
      if (to && m_tos[k] < 255) m_tos[k]++;
      if (!act || err_e || to) m_cnt[k] = 0;
      else m_cnt[k] = m_cnt[k] + int'(acc) - int'(ack_e);
      if (m_ab[k]) begin
        if (!c) m_ab[k] = 0;
      end else if (m_busy[k]) begin
        if (!c) m_busy[k] = 0;
        else if (err_e || to) begin m_busy[k] = 0; m_ab[k] = 1; end
      end else if (c) m_busy[k] = 1;
    end
  endtask

  task automatic idle2();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  int first[2];
  int acc_cnt;

  initial begin
    i_reset = 1; i_mcyc = 0; i_mstb = 0; i_mwe = 0; i_maddr = 0; i_mdata = 0;
    i_msel = 0; i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0; i_wb_data = 0;
    mreset();
    repeat (2) @(negedge i_clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_out", {wb_cyc[k], wb_stb[k], mack[k], merr[k], mstall[k], bus_reset[k], busy[k]}, 0);
      chk("rst_cnt", {outstanding[k], timeouts[k]}, 0);
    end
    @(negedge i_clk);
    i_reset = 0;

    // Single read, ack three cycles later.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rd_out1", outstanding[0], 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 32'hDEADBEEF);
    chk("rd_ack", {mack[0], merr[0], mdata[0]}, {1'b1, 1'b0, 32'hDEADBEEF});
    step(0, 0, 0, 0, 0, 0);
    chk("rd_out0", outstanding[0], 0);
    step(0, 0, 0, 0, 0, 0);

    // Continuous strobes with no acks: throttled at four.
    acc_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      step(1, 1, 0, 0, 0, 0);
      if (wb_stb[0] && !i_wb_stall) acc_cnt++;
      if (t == 3) chk("thr_stall3", mstall[0], 0);
      if (t == 4) chk("thr_stall4", mstall[0], 1);
    end
    chk("thr_acc", acc_cnt, 4);
    chk("thr_out", outstanding[0], 4);
    idle2();

    // One request, no ack: timeout reported at cycle 17, late ack ignored.
    first[0] = -1; first[1] = -1;
    for (int t = 0; t < 25; t++) begin
      step(1, t == 0, t == 22, 0, 0, 0);
      for (int k = 0; k < 2; k++) if (bus_reset[k] && first[k] < 0) first[k] = t;
      if (t == 17) chk("to_abort", {merr[0], wb_cyc[0]}, 2'b10);
      if (t == 18) chk("to_pulse1", {merr[0], bus_reset[0]}, 0);
      if (t == 22) chk("to_lateack", mack[0], 0);
    end
    chk("to_first0", first[0], 17);
    chk("to_first1", first[1], 17);
    chk("to_tally", {timeouts[0], timeouts[1]}, {8'd1, 8'd1});
    idle2();
    chk("to_idle", busy[0], 0);

    // Ack exactly at terminal watchdog value wins.
    first[0] = -1; first[1] = -1;
    for (int t = 0; t < 21; t++) begin
      step(1, t == 0, t == 16, 0, 0, 32'h1234);
      for (int k = 0; k < 2; k++) if (bus_reset[k] && first[k] < 0) first[k] = t;
      if (t == 16) chk("term_ack", {mack[0], merr[0]}, 2'b10);
    end
    chk("term_nobr", first[0], -1);
    chk("term_tally", timeouts[0], 1);
    idle2();

    // A request every 10 cycles: only the mode-0 watchdog fires.
    first[0] = -1; first[1] = -1;
    for (int t = 0; t < 30; t++) begin
      step(1, (t % 10) == 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) if (bus_reset[k] && first[k] < 0) first[k] = t;
    end
    chk("wd0_first", first[0], 17);
    chk("wd1_first", first[1], -1);
    chk("wd_tally", {timeouts[0], timeouts[1]}, {8'd2, 8'd1});
    idle2();

    // Asynchronous reset with three outstanding.
    repeat (3) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("mid_out3", outstanding[0], 3);
    #2 i_reset = 1;
    #1;
    for (int k = 0; k < 2; k++)
      chk("mid_rst", {wb_cyc[k], merr[k], outstanding[k], timeouts[k]}, 0);
    mreset();
    @(negedge i_clk);
    i_mcyc = 0; i_mstb = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_stall = 0;
    i_reset = 0;
    step(1, 0, 0, 0, 0, 0);
    chk("mid_idle", busy[0], 0);
    idle2();

    // Randomised traffic with varying ack density.
    for (int seg = 0; seg < 30; seg++) begin
      int pa;
      case ($urandom_range(3))
        0: pa = 0;
        1: pa = 5;
        2: pa = 30;
        default: pa = 70;
      endcase
      for (int t = 0; t < 100; t++) begin
        bit c;
        c = ($urandom_range(99) >= 3);
        step(c, c && ($urandom_range(1) == 1), $urandom_range(99) < pa,
             $urandom_range(3) == 0, $urandom_range(199) == 0, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
